bounded_counter: RTL and testbench
==================================

# bounded_counter

Parametrised up/down bounded counter: the next-generation general counter for the design. It replaces fixed 8-bit count-to-100 counters with configurable width, limits, direction, saturate/wrap mode, parallel load, and terminal/overflow flags. It sits beside control FSMs as a timeout, event or index counter, and is driven by a free-running clock plus an enable.

## Interface
- WIDTH, 8, counter width in bits (2..32).
- MIN_VAL, 0, lower bound of the count range.
- MAX_VAL, 100, upper bound of the count range. Must satisfy MIN_VAL < MAX_VAL ≤ 2^WIDTH−1.
- WRAP, 0, boundary behaviour: 0 = saturate at the bound, 1 = wrap to the opposite bound.
- PRESCALE, 4, enable divider ratio (≥1). Used only when BOUNDED_COUNTER_PRESCALE_EN is defined.
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable, sampled each cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- clr_flags  input  1  clears the sticky `ovf` flag.
- count  output  WIDTH  current count (registered).
- at_max  output  1  combinational: count == MAX_VAL.
- at_min  output  1  combinational: count == MIN_VAL.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  registered sticky boundary-hit flag.

## Operation
- Priority per cycle: rst > load > step (en) > hold.
- Reset: count=MIN_VAL, tc=0, ovf=0, prescaler=0.
- Load: count ← load_val clamped to [MIN_VAL, MAX_VAL]. A load is not a step, so tc=0 that cycle. Load does not change ovf.
- Step (en=1, no load):
  - up=1 and count<MAX_VAL: count+1.
  - up=0 and count>MIN_VAL: count−1.
- Boundary event: a step is attempted at the terminal value (up=1 at MAX_VAL, or up=0 at MIN_VAL).
  - WRAP=0: count holds.
  - WRAP=1: count → MIN_VAL (going up) or MAX_VAL (going down).
  - In both modes: tc=1 for the next cycle only, and ovf is set.
- ovf is cleared by clr_flags. If a boundary event and clr_flags occur in the same cycle, set wins.
- Arithmetic is done in WIDTH+1 bits internally. count never leaves [MIN_VAL, MAX_VAL] and never wraps through 2^WIDTH.
- A direction change mid-count takes effect on the next enabled step.

## Timing
- count, tc and ovf update on the rising edge after the qualifying inputs are sampled: 1-cycle latency.
- at_max and at_min follow count in the same cycle (0 latency from count).
- tc pulse width is exactly one cycle per boundary event. Back-to-back boundary events in saturate mode give tc high on consecutive cycles.
- rst asserted mid-count takes effect on the next edge regardless of en, load or up.
- load asserted in the same cycle as en: load wins, and the step is dropped.

## Configuration
- BOUNDED_COUNTER_PRESCALE_EN defined:
  - An internal divider counts cycles with en=1. A step, including a boundary event, occurs only on the PRESCALE-th such cycle; the divider then returns to 0.
  - The divider is cleared by rst and by load.
  - PRESCALE=1 is equivalent to the macro being undefined.
- BOUNDED_COUNTER_PRESCALE_EN undefined:
  - Every en=1 cycle is a step.
  - No divider logic is present and PRESCALE is ignored.

## Test plan
- Reset: assert rst for 2 cycles with en=1 -> count=0, tc=0, ovf=0, at_min=1.
- Saturate up (defaults): rst, then en=1, up=1 for 101 cycles -> count reaches 100 after the 100th cycle and holds at 100. tc pulses once after cycle 101 and ovf=1. clr_flags -> ovf=0.
- Wrap down (WRAP=1, MIN_VAL=3, MAX_VAL=9): load 4, then en=1, up=0 for 3 cycles -> 3, 9 (tc pulse), 8. at_max is high while count=9.
- Load clamp and priority: load_val=200 with en=1 -> count=100. load_val=1 with MIN_VAL=3 -> count=3. No tc pulse in either case.
- Mid-operation reset: count up to 57, then assert rst together with load=1 and en=1 -> count=0 on the next cycle and ovf=0.
- Prescale (macro defined, PRESCALE=4): en=1 for 12 cycles from reset -> count=3, incrementing on cycles 4, 8 and 12. Load at cycle 6 restarts the divider, so the next step occurs 4 enabled cycles after the load.

Source files
------------

// File: rtl/bounded_counter.sv
// rtl/bounded_counter.sv - parametrised up/down bounded counter with load, terminal pulse and sticky overflow
//
// Purpose:
//   General-purpose event/timeout/index counter. The count is confined to
//   [MIN_VAL, MAX_VAL]. At a bound it either saturates (WRAP=0) or wraps to
//   the opposite bound (WRAP=1). Every step attempted at a bound pulses tc
//   for one cycle and sets the sticky ovf flag.
//
// Optional feature:
//   BOUNDED_COUNTER_PRESCALE_EN - when defined, enabled cycles are divided by
//   PRESCALE. Only every PRESCALE-th cycle with en=1 is a step. When the
//   macro is undefined, every en=1 cycle is a step and PRESCALE is only
//   range-checked.
//
// Parameters:
//   WIDTH     counter width in bits (2..32)
//   MIN_VAL   lower bound of the count range
//   MAX_VAL   upper bound of the count range (MIN_VAL < MAX_VAL <= 2^WIDTH-1)
//   WRAP      0 = saturate at the bound, 1 = wrap to the opposite bound
//   PRESCALE  enable divider ratio (>= 1)
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   en         in   1      count enable
//   up         in   1      direction: 1 = increment, 0 = decrement
//   load       in   1      parallel load strobe (beats en)
//   load_val   in   WIDTH  value to load, clamped into range
//   clr_flags  in   1      clears ovf (a same-cycle boundary event wins)
//   count      out  WIDTH  registered count
//   at_max     out  1      count == MAX_VAL
//   at_min     out  1      count == MIN_VAL
//   tc         out  1      one-cycle pulse after a boundary event
//   ovf        out  1      sticky boundary-hit flag

module bounded_counter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MIN_VAL  = 0,
    parameter int unsigned MAX_VAL  = 100,
    parameter int unsigned WRAP     = 0,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf
);

    // Elaboration-time parameter sanity.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("bounded_counter: WIDTH must be in 2..32");
    end
    if (MIN_VAL >= MAX_VAL) begin : g_bad_range
        $error("bounded_counter: MIN_VAL must be below MAX_VAL");
    end
    if (64'(MAX_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("bounded_counter: MAX_VAL does not fit in WIDTH bits");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("bounded_counter: PRESCALE must be at least 1");
    end
    if (WRAP > 1) begin : g_bad_wrap
        $error("bounded_counter: WRAP must be 0 or 1");
    end

    // Bounds in the widened arithmetic domain (one guard bit above WIDTH) so
    // that +1 at an all-ones MAX_VAL cannot silently roll through zero.
    localparam logic [WIDTH:0]   MIN_EXT = (WIDTH + 1)'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic             step;       // an enabled step happens this cycle (load already excluded)
    logic             boundary;   // step attempted at the terminal value for the current direction
    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   clamped;
    logic [WIDTH:0]   next_ext;
    logic             unused_next_msb;

    //------------------------------------------------------------------
    // Step qualification
    //------------------------------------------------------------------
`ifdef BOUNDED_COUNTER_PRESCALE_EN
    localparam int unsigned      DIV_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] div;

    // Counts enabled cycles; the PRESCALE-th one is the step and returns the
    // divider to zero. A load restarts the divider so the first step after
    // a load is a full PRESCALE enabled cycles away.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            div <= '0;
        end else if (en) begin
            if (div == DIV_LAST) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    assign step = en && !load && (div == DIV_LAST);
`else
    assign step = en && !load;
`endif

    //------------------------------------------------------------------
    // Next-count datapath
    //------------------------------------------------------------------
    assign count_ext = {1'b0, count};
    assign load_ext  = {1'b0, load_val};

    always_comb begin
        clamped = load_ext;
        if (load_ext < MIN_EXT) begin
            clamped = MIN_EXT;
        end else if (load_ext > MAX_EXT) begin
            clamped = MAX_EXT;
        end
    end

    assign boundary = step && ((up && (count_ext == MAX_EXT)) ||
                               (!up && (count_ext == MIN_EXT)));

    always_comb begin
        next_ext = count_ext;
        if (load) begin
            next_ext = clamped;
        end else if (step) begin
            if (up) begin
                if (count_ext == MAX_EXT) begin
                    next_ext = (WRAP != 0) ? MIN_EXT : MAX_EXT;
                end else begin
                    next_ext = count_ext + 1'b1;
                end
            end else begin
                if (count_ext == MIN_EXT) begin
                    next_ext = (WRAP != 0) ? MAX_EXT : MIN_EXT;
                end else begin
                    next_ext = count_ext - 1'b1;
                end
            end
        end
    end

    // next_ext always lies inside [MIN_VAL, MAX_VAL], so the guard bit is zero.
    assign unused_next_msb = next_ext[WIDTH];

    //------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= MIN_W;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_ext[WIDTH-1:0];
            tc    <= boundary;
            // Setting beats clearing when both happen in one cycle.
            if (boundary) begin
                ovf <= 1'b1;
            end else if (clr_flags) begin
                ovf <= 1'b0;
            end
        end
    end

    //------------------------------------------------------------------
    // Combinational status
    //------------------------------------------------------------------
    assign at_max = (count == MAX_W);
    assign at_min = (count == MIN_W);

endmodule

// File: tb/tb_bounded_counter.sv
// tb/tb_bounded_counter.sv - randomized self-checking bench for bounded_counter against a behavioural model

module tb_bounded_counter;

`ifdef BOUNDED_COUNTER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif
    localparam int A_MIN = 0;
    localparam int A_MAX = 100;
    localparam int B_MIN = 3;
    localparam int B_MAX = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] a_count;
    logic       a_at_max, a_at_min, a_tc, a_ovf;
    logic [3:0] b_count;
    logic       b_at_max, b_at_min, b_tc, b_ovf;

    int checks = 0;
    int failures = 0;

    // Model state: instance A (0..100 saturate), instance B (3..9 wrap)
    int ma_cnt, ma_tc, ma_ovf, ma_div;
    int mb_cnt, mb_tc, mb_ovf, mb_div;

    always #5 clk = ~clk;

    bounded_counter #(
        .WIDTH(8), .MIN_VAL(A_MIN), .MAX_VAL(A_MAX), .WRAP(0), .PRESCALE(PS)
    ) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr_flags(clr_flags),
        .count(a_count), .at_max(a_at_max), .at_min(a_at_min),
        .tc(a_tc), .ovf(a_ovf)
    );

    bounded_counter #(
        .WIDTH(4), .MIN_VAL(B_MIN), .MAX_VAL(B_MAX), .WRAP(1), .PRESCALE(PS)
    ) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_val(load_val[3:0]), .clr_flags(clr_flags),
        .count(b_count), .at_max(b_at_max), .at_min(b_at_min),
        .tc(b_tc), .ovf(b_ovf)
    );

    // Reference behaviour for one clock edge, straight from the operating rules.
    task automatic model(input int mn, input int mx, input int wr, input int lv,
                         inout int cnt, inout int tcv, inout int ovfv, inout int div);
        int  boundary;
        bit  fire;
        boundary = 0;
        fire     = 1'b0;
        if (rst) begin
            cnt = mn; tcv = 0; ovfv = 0; div = 0;
            return;
        end
        if (load) begin
            cnt = (lv < mn) ? mn : ((lv > mx) ? mx : lv);
            tcv = 0;
            div = 0;
            if (clr_flags) ovfv = 0;
            return;
        end
        if (en) begin
            div = div + 1;
            if (div == PS) begin
                fire = 1'b1;
                div  = 0;
            end
        end
        if (fire) begin
            if (up) begin
                if (cnt == mx) begin
                    boundary = 1;
                    if (wr != 0) cnt = mn;
                end else begin
                    cnt = cnt + 1;
                end
            end else begin
                if (cnt == mn) begin
                    boundary = 1;
                    if (wr != 0) cnt = mx;
                end else begin
                    cnt = cnt - 1;
                end
            end
        end
        tcv = boundary;
        if (boundary != 0) ovfv = 1;
        else if (clr_flags) ovfv = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model(A_MIN, A_MAX, 0, int'(load_val), ma_cnt, ma_tc, ma_ovf, ma_div);
        model(B_MIN, B_MAX, 1, int'(load_val[3:0]), mb_cnt, mb_tc, mb_ovf, mb_div);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; up = 1'b1;
        tick(); tick();
        checks++; if (a_count !== 8'd0) begin failures++; $display("FAIL reset_a_count got=%0d exp=0", a_count); end
        checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL reset_a_tc got=%b exp=0", a_tc); end
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL reset_a_ovf got=%b exp=0", a_ovf); end
        checks++; if (a_at_min !== 1'b1) begin failures++; $display("FAIL reset_a_at_min got=%b exp=1", a_at_min); end
        checks++; if (b_count !== 4'd3) begin failures++; $display("FAIL reset_b_count got=%0d exp=3", b_count); end
        checks++; if (b_at_min !== 1'b1) begin failures++; $display("FAIL reset_b_at_min got=%b exp=1", b_at_min); end
        idle_inputs();
    endtask

    task automatic test_saturate_up();
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 101 * PS; i++) begin
            tick();
            checks++; if (a_count !== 8'(ma_cnt)) begin failures++; $display("FAIL sat_a_count i=%0d got=%0d exp=%0d", i, a_count, ma_cnt); end
            checks++; if (a_tc !== 1'(ma_tc)) begin failures++; $display("FAIL sat_a_tc i=%0d got=%b exp=%0d", i, a_tc, ma_tc); end
            checks++; if (b_count !== 4'(mb_cnt)) begin failures++; $display("FAIL sat_b_count i=%0d got=%0d exp=%0d", i, b_count, mb_cnt); end
            if (i == 100 * PS) begin
                checks++; if (a_count !== 8'd100) begin failures++; $display("FAIL sat_reach100 got=%0d exp=100", a_count); end
                checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf_early got=%b exp=0", a_ovf); end
            end
        end
        checks++; if (a_count !== 8'd100) begin failures++; $display("FAIL sat_hold got=%0d exp=100", a_count); end
        checks++; if (a_tc !== 1'b1) begin failures++; $display("FAIL sat_tc got=%b exp=1", a_tc); end
        checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf got=%b exp=1", a_ovf); end
        checks++; if (a_at_max !== 1'b1) begin failures++; $display("FAIL sat_at_max got=%b exp=1", a_at_max); end
        en = 1'b0; tick();
        checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL sat_tc_width got=%b exp=0", a_tc); end
        checks++; if (a_ovf !== 1'b1) begin failures++; $display("FAIL sat_ovf_sticky got=%b exp=1", a_ovf); end
        clr_flags = 1'b1; tick(); clr_flags = 1'b0;
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL sat_clr_ovf got=%b exp=0", a_ovf); end
        idle_inputs();
    endtask

    task automatic test_wrap_down();
        int exp_seq [3];
        exp_seq = '{3, 9, 8};
        load = 1'b1; load_val = 8'd4; tick(); load = 1'b0;
        checks++; if (b_count !== 4'd4) begin failures++; $display("FAIL wrap_load got=%0d exp=4", b_count); end
        en = 1'b1; up = 1'b0;
        for (int s = 0; s < 3; s++) begin
            repeat (PS) tick();
            checks++; if (b_count !== 4'(exp_seq[s])) begin failures++; $display("FAIL wrap_count s=%0d got=%0d exp=%0d", s, b_count, exp_seq[s]); end
            checks++; if (b_tc !== (s == 1)) begin failures++; $display("FAIL wrap_tc s=%0d got=%b exp=%b", s, b_tc, (s == 1)); end
            checks++; if (b_at_max !== (exp_seq[s] == 9)) begin failures++; $display("FAIL wrap_at_max s=%0d got=%b exp=%b", s, b_at_max, (exp_seq[s] == 9)); end
            checks++; if (a_count !== 8'(ma_cnt)) begin failures++; $display("FAIL wrap_a_count s=%0d got=%0d exp=%0d", s, a_count, ma_cnt); end
        end
        checks++; if (b_ovf !== 1'b1) begin failures++; $display("FAIL wrap_ovf got=%b exp=1", b_ovf); end
        idle_inputs();
    endtask

    task automatic test_load_clamp();
        en = 1'b1; up = 1'b1; load = 1'b1; load_val = 8'd200;
        tick();
        checks++; if (a_count !== 8'd100) begin failures++; $display("FAIL clamp_hi_a got=%0d exp=100", a_count); end
        checks++; if (a_tc !== 1'b0) begin failures++; $display("FAIL clamp_hi_a_tc got=%b exp=0", a_tc); end
        checks++; if (b_count !== 4'd8) begin failures++; $display("FAIL clamp_hi_b got=%0d exp=8", b_count); end
        load_val = 8'd1;
        tick();
        checks++; if (a_count !== 8'd1) begin failures++; $display("FAIL clamp_lo_a got=%0d exp=1", a_count); end
        checks++; if (b_count !== 4'd3) begin failures++; $display("FAIL clamp_lo_b got=%0d exp=3", b_count); end
        checks++; if (b_tc !== 1'b0) begin failures++; $display("FAIL clamp_lo_b_tc got=%b exp=0", b_tc); end
        load_val = 8'd15;
        tick();
        checks++; if (b_count !== 4'd9) begin failures++; $display("FAIL clamp_top_b got=%0d exp=9", b_count); end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; up = 1'b1;
        repeat (57 * PS) tick();
        checks++; if (a_count !== 8'd57) begin failures++; $display("FAIL midrst_pre got=%0d exp=57", a_count); end
        checks++; if (b_ovf !== 1'(mb_ovf)) begin failures++; $display("FAIL midrst_b_ovf_pre got=%b exp=%0d", b_ovf, mb_ovf); end
        rst = 1'b1; load = 1'b1; load_val = 8'd80;
        tick();
        checks++; if (a_count !== 8'd0) begin failures++; $display("FAIL midrst_a got=%0d exp=0", a_count); end
        checks++; if (a_ovf !== 1'b0) begin failures++; $display("FAIL midrst_a_ovf got=%b exp=0", a_ovf); end
        checks++; if (b_count !== 4'd3) begin failures++; $display("FAIL midrst_b got=%0d exp=3", b_count); end
        checks++; if (b_ovf !== 1'b0) begin failures++; $display("FAIL midrst_b_ovf got=%b exp=0", b_ovf); end
        idle_inputs();
    endtask

    task automatic test_prescale();
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++; if (a_count !== 8'(i / PS)) begin failures++; $display("FAIL pre_count i=%0d got=%0d exp=%0d", i, a_count, i / PS); end
        end
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (5) tick();
        load = 1'b1; load_val = 8'd20; tick(); load = 1'b0;
        checks++; if (a_count !== 8'd20) begin failures++; $display("FAIL pre_load got=%0d exp=20", a_count); end
        for (int j = 1; j <= PS; j++) begin
            tick();
            checks++; if (a_count !== 8'(20 + j / PS)) begin failures++; $display("FAIL pre_restart j=%0d got=%0d exp=%0d", j, a_count, 20 + j / PS); end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int tc_seen;
        tc_seen = 0;
        load = 1'b1; load_val = 8'd99; tick(); load = 1'b0;
        en = 1'b1; up = 1'b1; clr_flags = 1'b1;
        for (int i = 0; i < 4 * PS; i++) begin
            tick();
            if (a_tc === 1'b1) tc_seen++;
            checks++; if (a_count !== 8'(ma_cnt)) begin failures++; $display("FAIL b2b_count i=%0d got=%0d exp=%0d", i, a_count, ma_cnt); end
            checks++; if (a_tc !== 1'(ma_tc)) begin failures++; $display("FAIL b2b_tc i=%0d got=%b exp=%0d", i, a_tc, ma_tc); end
            checks++; if (a_ovf !== 1'(ma_ovf)) begin failures++; $display("FAIL b2b_ovf i=%0d got=%b exp=%0d", i, a_ovf, ma_ovf); end
        end
        checks++; if (tc_seen != 3) begin failures++; $display("FAIL b2b_tc_pulses got=%0d exp=3", tc_seen); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            load      = ($urandom_range(0, 11) == 0);
            en        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            clr_flags = ($urandom_range(0, 7) == 0);
            load_val  = 8'($urandom_range(0, 255));
            tick();
            checks++; if (a_count !== 8'(ma_cnt)) begin failures++; $display("FAIL rnd_a_count c=%0d got=%0d exp=%0d", c, a_count, ma_cnt); end
            checks++; if (a_tc !== 1'(ma_tc)) begin failures++; $display("FAIL rnd_a_tc c=%0d got=%b exp=%0d", c, a_tc, ma_tc); end
            checks++; if (a_ovf !== 1'(ma_ovf)) begin failures++; $display("FAIL rnd_a_ovf c=%0d got=%b exp=%0d", c, a_ovf, ma_ovf); end
            checks++; if (a_at_max !== (ma_cnt == A_MAX)) begin failures++; $display("FAIL rnd_a_at_max c=%0d got=%b exp=%b", c, a_at_max, (ma_cnt == A_MAX)); end
            checks++; if (a_at_min !== (ma_cnt == A_MIN)) begin failures++; $display("FAIL rnd_a_at_min c=%0d got=%b exp=%b", c, a_at_min, (ma_cnt == A_MIN)); end
            checks++; if (b_count !== 4'(mb_cnt)) begin failures++; $display("FAIL rnd_b_count c=%0d got=%0d exp=%0d", c, b_count, mb_cnt); end
            checks++; if (b_tc !== 1'(mb_tc)) begin failures++; $display("FAIL rnd_b_tc c=%0d got=%b exp=%0d", c, b_tc, mb_tc); end
            checks++; if (b_ovf !== 1'(mb_ovf)) begin failures++; $display("FAIL rnd_b_ovf c=%0d got=%b exp=%0d", c, b_ovf, mb_ovf); end
            checks++; if (b_at_max !== (mb_cnt == B_MAX)) begin failures++; $display("FAIL rnd_b_at_max c=%0d got=%b exp=%b", c, b_at_max, (mb_cnt == B_MAX)); end
            checks++; if (b_at_min !== (mb_cnt == B_MIN)) begin failures++; $display("FAIL rnd_b_at_min c=%0d got=%b exp=%b", c, b_at_min, (mb_cnt == B_MIN)); end
        end
        idle_inputs();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_saturate_up();
        test_wrap_down();
        test_load_clamp();
        test_mid_reset();
        test_prescale();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
